ss_display_arbiter: RTL and testbench
=====================================

Name: ss_display_arbiter

Overview:
- Shares the 4-digit seven-segment display between two message requesters and an idle default source.
- Generates the BCD3..BCD0 digits and the PWM brightness-gate signal consumed by the seven-segment driver.
- A granted request owns the display for a fixed hold time. Simultaneous requests are resolved round-robin.
- Sits between application logic (clock/counter, status messages) and the display driver.

Parameters:
- TICK_DIV, 100000: Clk cycles per hold tick (1 ms at 100 MHz); must be >= 2.
- HOLD_TICKS, 200: ticks a granted message stays on the display; must be >= 1.
- PWM_BITS, 4: width of the brightness input and the PWM counter.

Ports:
- Clk  in  1  system clock, 100 MHz.
- Reset  in  1  synchronous, active-high.
- Brightness  in  PWM_BITS  duty setting; 0 = dark, all-ones = (2^PWM_BITS - 1)/2^PWM_BITS duty.
- DefData  in  16  idle display value {BCD3,BCD2,BCD1,BCD0}.
- ReqA  in  1  requester A level request.
- DataA  in  16  requester A message; sampled at grant.
- ReqB  in  1  requester B level request.
- DataB  in  16  requester B message; sampled at grant.
- GntA, GntB  out  1 each  one-cycle pulse on acceptance.
- DoneA, DoneB  out  1 each  one-cycle pulse when the hold time expires.
- Busy  out  1  high while a message owns the display.
- BCD3, BCD2, BCD1, BCD0  out  4 each  registered digits to the driver.
- PWM  out  1  brightness gate to the driver.

Behaviour:
- Reset: state IDLE; all Gnt*, Done*, and Busy = 0; BCD* = 0; PWM = 0; LastGnt = B, so A wins the first tie; divider, hold, and PWM counters = 0.
- FSM states: IDLE, SHOW_A, SHOW_B.
- IDLE:
  - Each cycle, register BCD* <= DefData (1-cycle latency).
  - If exactly one Req is high, grant it.
  - If both are high, grant the requester not equal to LastGnt.
  - On grant: pulse Gnt for 1 cycle, latch Data into the message register, set LastGnt, clear the divider and hold counters, go to SHOW_x, assert Busy.
- SHOW_x:
  - BCD* <= latched message from the first SHOW cycle, so the new digits appear in the cycle after the grant.
  - Req and Data changes are ignored. No preemption.
  - The divider counts 0..TICK_DIV-1; tick = (div == TICK_DIV-1).
  - The hold counter increments on each tick.
  - On the tick where hold == HOLD_TICKS-1: pulse Done_x, clear Busy, return to IDLE.
  - Display time is exactly HOLD_TICKS*TICK_DIV cycles, from the cycle after Gnt to the cycle Done is asserted, inclusive.
- Re-arbitration: IDLE always lasts at least 1 cycle between messages. A request still high at Done is re-arbitrated the next cycle.
- Requester rule: drop Req on seeing Gnt. A Req held high causes a repeat display.
- PWM:
  - A free-running PWM_BITS counter wraps naturally at 2^PWM_BITS.
  - PWM register <= (pwm_cnt < Brightness), 1-cycle latency.
  - Brightness = 0 gives constant 0.
  - A Brightness change takes effect at the next compare, with no glitch suppression.
- Widths: the hold counter is sized with clog2(HOLD_TICKS+1) and the divider with clog2(TICK_DIV); neither may overflow.
- Reset mid-SHOW: abort immediately to the reset values. No Done is issued for the aborted message.

Optional Feature:
- Macro SS_ARB_BLINK_EN.
- Defined:
  - Adds an input Blink, 1 bit, sampled at grant together with Data.
  - If the latched Blink = 1 in SHOW_x, PWM is forced 0 during odd tick periods (hold counter bit 0 = 1), giving a blink period of 2 ticks.
  - IDLE is never blinked.
- Undefined: no Blink port, and PWM depends only on Brightness.

Test Plan (TICK_DIV=4, HOLD_TICKS=3, PWM_BITS=4):
- Reset held 3 cycles with DefData=16'h1234 -> all outputs 0 during reset; BCD3..0 = 1,2,3,4 one cycle after Reset falls; Busy=0.
- ReqA pulse with DataA=16'h0042 -> GntA 1 cycle; BCD = 0,0,4,2 next cycle; Busy high 12 cycles; DoneA on the 12th cycle; BCD returns to DefData the following cycle.
- ReqA and ReqB both held high from reset -> grant order A, B, A, B; each Gnt separated by 12 SHOW cycles plus 1 IDLE cycle.
- Reset asserted 5 cycles into SHOW_B -> no DoneB; Busy=0 and BCD=0 next cycle; IDLE with DefData after release.
- Brightness=4 -> PWM high 4 of every 16 cycles; Brightness=0 -> never high; Brightness=15 -> 15/16.
- (SS_ARB_BLINK_EN) Blink=1, Brightness=15 -> PWM forced 0 during cycles 5-8 of SHOW; normal duty in cycles 1-4 and 9-12.

Source files
------------

// File: rtl/ss_display_arbiter.sv
// ss_display_arbiter
// Shares a 4-digit seven-segment display between two message requesters
// (A, B) and an idle default value. A granted message owns the display for
// HOLD_TICKS ticks of TICK_DIV cycles each. Simultaneous requests alternate
// round-robin. Also produces the PWM brightness gate for the display driver.
//
// Optional feature: define SS_ARB_BLINK_EN to add the Blink input. A message
// granted with Blink=1 has PWM forced low on every odd hold tick.
//
// Ports:
//   Clk, Reset          clock, synchronous active-high reset
//   Brightness          PWM duty (0 = dark)
//   DefData             idle display value {BCD3,BCD2,BCD1,BCD0}
//   ReqA/DataA          requester A level request and message
//   ReqB/DataB          requester B level request and message
//   GntA/GntB           one-cycle grant pulses
//   DoneA/DoneB         one-cycle pulses when the hold time expires
//   Busy                high while a message owns the display
//   BCD3..BCD0          registered digits to the driver
//   PWM                 registered brightness gate
//   Blink               (SS_ARB_BLINK_EN only) blink request, sampled at grant
module ss_display_arbiter #(
    parameter int unsigned TICK_DIV   = 100000,
    parameter int unsigned HOLD_TICKS = 200,
    parameter int unsigned PWM_BITS   = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [PWM_BITS-1:0] Brightness,
    input  logic [15:0]         DefData,
    input  logic                ReqA,
    input  logic [15:0]         DataA,
    input  logic                ReqB,
    input  logic [15:0]         DataB,
    output logic                GntA,
    output logic                GntB,
    output logic                DoneA,
    output logic                DoneB,
    output logic                Busy,
    output logic [3:0]          BCD3,
    output logic [3:0]          BCD2,
    output logic [3:0]          BCD1,
    output logic [3:0]          BCD0,
    output logic                PWM
`ifdef SS_ARB_BLINK_EN
    ,
    input  logic                Blink
`endif
);

    localparam int unsigned DIV_W  = $clog2(TICK_DIV);
    localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW_A = 2'd1,
        SHOW_B = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic                last_b_q, last_b_d;   // 1 = B was granted last
    logic [15:0]         msg_q, msg_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                gnt_a_q, gnt_a_d;
    logic                gnt_b_q, gnt_b_d;
    logic                done_a_q, done_a_d;
    logic                done_b_q, done_b_d;
    logic                busy_q, busy_d;
    logic [15:0]         bcd_q, bcd_d;
    logic                pwm_q, pwm_d;
`ifdef SS_ARB_BLINK_EN
    logic                blink_q, blink_d;
`endif

    logic grant_a_c, grant_b_c, showing_c, tick_c, last_tick_c;

    // Arbitration: a lone request wins; on a tie the one not granted last wins
    assign grant_a_c   = (state_q == IDLE) && ReqA && (!ReqB || last_b_q);
    assign grant_b_c   = (state_q == IDLE) && ReqB && (!ReqA || !last_b_q);
    assign showing_c   = (state_q == SHOW_A) || (state_q == SHOW_B);
    assign tick_c      = showing_c && (div_q == DIV_LAST);
    assign last_tick_c = tick_c && (hold_q == HOLD_LAST);

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_a_c) begin
                    state_d = SHOW_A;
                end else if (grant_b_c) begin
                    state_d = SHOW_B;
                end
            end
            SHOW_A, SHOW_B: begin
                if (last_tick_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        gnt_a_d   = grant_a_c;
        gnt_b_d   = grant_b_c;
        done_a_d  = last_tick_c && (state_q == SHOW_A);
        done_b_d  = last_tick_c && (state_q == SHOW_B);
        busy_d    = (state_d != IDLE);
        bcd_d     = showing_c ? msg_q : DefData;
        msg_d     = msg_q;
        last_b_d  = last_b_q;
        div_d     = div_q;
        hold_d    = hold_q;
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        pwm_d     = (pwm_cnt_q < Brightness);
`ifdef SS_ARB_BLINK_EN
        blink_d   = blink_q;
`endif

        if (grant_a_c) begin
            msg_d    = DataA;
            last_b_d = 1'b0;
            div_d    = '0;
            hold_d   = '0;
`ifdef SS_ARB_BLINK_EN
            blink_d  = Blink;
`endif
        end else if (grant_b_c) begin
            msg_d    = DataB;
            last_b_d = 1'b1;
            div_d    = '0;
            hold_d   = '0;
`ifdef SS_ARB_BLINK_EN
            blink_d  = Blink;
`endif
        end else if (showing_c) begin
            if (tick_c) begin
                div_d  = '0;
                hold_d = hold_q + HOLD_W'(1);
            end else begin
                div_d  = div_q + DIV_W'(1);
            end
        end

`ifdef SS_ARB_BLINK_EN
        // Dark on odd tick periods of a blinking message
        if (showing_c && blink_q && hold_q[0]) begin
            pwm_d = 1'b0;
        end
`endif
    end

    // Datapath and output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            last_b_q  <= 1'b1;
            msg_q     <= '0;
            div_q     <= '0;
            hold_q    <= '0;
            pwm_cnt_q <= '0;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            busy_q    <= 1'b0;
            bcd_q     <= '0;
            pwm_q     <= 1'b0;
`ifdef SS_ARB_BLINK_EN
            blink_q   <= 1'b0;
`endif
        end else begin
            last_b_q  <= last_b_d;
            msg_q     <= msg_d;
            div_q     <= div_d;
            hold_q    <= hold_d;
            pwm_cnt_q <= pwm_cnt_d;
            gnt_a_q   <= gnt_a_d;
            gnt_b_q   <= gnt_b_d;
            done_a_q  <= done_a_d;
            done_b_q  <= done_b_d;
            busy_q    <= busy_d;
            bcd_q     <= bcd_d;
            pwm_q     <= pwm_d;
`ifdef SS_ARB_BLINK_EN
            blink_q   <= blink_d;
`endif
        end
    end

    assign GntA  = gnt_a_q;
    assign GntB  = gnt_b_q;
    assign DoneA = done_a_q;
    assign DoneB = done_b_q;
    assign Busy  = busy_q;
    assign BCD3  = bcd_q[15:12];
    assign BCD2  = bcd_q[11:8];
    assign BCD1  = bcd_q[7:4];
    assign BCD0  = bcd_q[3:0];
    assign PWM   = pwm_q;

endmodule

// File: tb/tb_ss_display_arbiter.sv
// Directed bench for ss_display_arbiter with TICK_DIV=4, HOLD_TICKS=3,
// PWM_BITS=4. Expected display values and grant order are queued as
// stimulus is applied and popped when the design produces them.
module tb_ss_display_arbiter;

    localparam int unsigned TD = 4;
    localparam int unsigned HT = 3;
    localparam int unsigned PB = 4;
    localparam int SHOW_CYC = TD * HT;

    logic          Clk;
    logic          Reset;
    logic [PB-1:0] Brightness;
    logic [15:0]   DefData;
    logic          ReqA, ReqB;
    logic [15:0]   DataA, DataB;
    logic          GntA, GntB, DoneA, DoneB, Busy, PWM;
    logic [3:0]    BCD3, BCD2, BCD1, BCD0;
`ifdef SS_ARB_BLINK_EN
    logic          Blink;
`endif
    logic [15:0]   bcd_w;

    assign bcd_w = {BCD3, BCD2, BCD1, BCD0};

    ss_display_arbiter #(
        .TICK_DIV  (TD),
        .HOLD_TICKS(HT),
        .PWM_BITS  (PB)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Brightness(Brightness),
        .DefData   (DefData),
        .ReqA      (ReqA),
        .DataA     (DataA),
        .ReqB      (ReqB),
        .DataB     (DataB),
        .GntA      (GntA),
        .GntB      (GntB),
        .DoneA     (DoneA),
        .DoneB     (DoneB),
        .Busy      (Busy),
        .BCD3      (BCD3),
        .BCD2      (BCD2),
        .BCD1      (BCD1),
        .BCD0      (BCD0),
        .PWM       (PWM)
`ifdef SS_ARB_BLINK_EN
        ,
        .Blink     (Blink)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_data_q[$];
    int          exp_who_q[$];   // 0 = A, 1 = B

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    initial begin
        int n;
        int hi;
        int ngnt;
        int cyc;
        int last_cyc;
        int who;
        int bad;
        int pwm_set[3];

        Reset = 1'b1;
        ReqA = 1'b0;
        ReqB = 1'b0;
        DataA = 16'h0000;
        DataB = 16'h0000;
        DefData = 16'h1234;
        Brightness = '0;
`ifdef SS_ARB_BLINK_EN
        Blink = 1'b0;
`endif

        // Reset held for 3 clock edges
        step(1);
        chk("reset_outputs_1", 32'({GntA, GntB, DoneA, DoneB, Busy, PWM, bcd_w}), 32'd0);
        step(2);
        chk("reset_outputs_3", 32'({GntA, GntB, DoneA, DoneB, Busy, PWM, bcd_w}), 32'd0);
        Reset = 1'b0;
        exp_data_q.push_back(DefData);
        step(1);
        chk("idle_bcd", 32'(bcd_w), 32'(exp_data_q.pop_front()));
        chk("idle_busy", 32'(Busy), 32'd0);

        // Single request from A
        DataA = 16'h0042;
        ReqA = 1'b1;
        exp_data_q.push_back(16'h0042);
        step(1);
        chk("gnt_a", 32'({GntA, GntB, Busy}), 32'b101);
        chk("bcd_before_show", 32'(bcd_w), 32'h1234);
        ReqA = 1'b0;
        DataA = 16'hFFFF;
        step(1);
        chk("gnt_a_pulse", 32'(GntA), 32'd0);
        chk("bcd_msg", 32'(bcd_w), 32'(exp_data_q.pop_front()));
        n = 1;
        for (int i = 0; i < 64 && Busy; i++) begin
            n++;
            step(1);
        end
        chk("busy_len", 32'(n), 32'(SHOW_CYC));
        chk("done_a", 32'({DoneA, DoneB}), 32'b10);
        chk("bcd_at_done", 32'(bcd_w), 32'h0042);
        step(1);
        chk("bcd_back_def", 32'(bcd_w), 32'h1234);
        chk("done_a_pulse", 32'(DoneA), 32'd0);

        // PWM duty over one full counter period
        pwm_set[0] = 4;
        pwm_set[1] = 0;
        pwm_set[2] = 15;
        for (int k = 0; k < 3; k++) begin
            Brightness = PB'(pwm_set[k]);
            step(1);
            hi = 0;
            for (int c = 0; c < 16; c++) begin
                if (PWM) hi++;
                step(1);
            end
            chk("pwm_duty", 32'(hi), 32'(pwm_set[k]));
        end

        // Both requests held high from reset: A, B, A, B
        Reset = 1'b1;
        ReqA = 1'b1;
        ReqB = 1'b1;
        DataA = 16'hA1A1;
        DataB = 16'hB2B2;
        step(2);
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_who_q.push_back(k % 2);
            exp_data_q.push_back((k % 2 == 0) ? 16'hA1A1 : 16'hB2B2);
        end
        ngnt = 0;
        cyc = 0;
        last_cyc = 0;
        for (int i = 0; i < 120 && ngnt < 4; i++) begin
            step(1);
            cyc++;
            if (GntA || GntB) begin
                who = exp_who_q.pop_front();
                chk("gnt_order", 32'({GntA, GntB}), (who == 0) ? 32'b10 : 32'b01);
                if (ngnt > 0) chk("gnt_gap", 32'(cyc - last_cyc), 32'(SHOW_CYC + 1));
                last_cyc = cyc;
                ngnt++;
                if (ngnt == 4) begin
                    ReqA = 1'b0;
                    ReqB = 1'b0;
                end
                step(1);
                cyc++;
                chk("rr_bcd", 32'(bcd_w), 32'(exp_data_q.pop_front()));
            end
        end
        chk("rr_grant_count", 32'(ngnt), 32'd4);

        // Reset five cycles into SHOW_B aborts without DoneB
        step(3);
        Reset = 1'b1;
        step(1);
        chk("abort_outputs", 32'({GntA, GntB, DoneA, DoneB, Busy, bcd_w}), 32'd0);
        Reset = 1'b0;
        step(1);
        chk("abort_idle_bcd", 32'(bcd_w), 32'h1234);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (DoneB || Busy) bad++;
            step(1);
        end
        chk("abort_no_done", 32'(bad), 32'd0);

`ifdef SS_ARB_BLINK_EN
        // Blinking message: PWM dark in SHOW cycles 5-8
        Brightness = 4'd15;
        Blink = 1'b1;
        DataA = 16'h0777;
        ReqA = 1'b1;
        step(1);
        chk("blink_gnt", 32'(GntA), 32'd1);
        ReqA = 1'b0;
        Blink = 1'b0;
        hi = 0;
        for (int k = 1; k <= SHOW_CYC; k++) begin
            step(1);
            if (k >= 5 && k <= 8) chk("blink_dark", 32'(PWM), 32'd0);
            else if (PWM) hi++;
        end
        chk("blink_lit", 32'(hi >= 7), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
